// File: rtl/menshen_ctrl_data_arb_if.sv
// rtl/menshen_ctrl_data_arb_if.sv - AXI-Stream bundle shared by the arbiter inputs and output
interface menshen_ctrl_data_arb_if #(
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/menshen_ctrl_data_arb.sv
// rtl/menshen_ctrl_data_arb.sv - packet-atomic 2:1 control/data stream arbiter with starvation guard
module menshen_ctrl_data_arb #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int STARVE_LIMIT         = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    menshen_ctrl_data_arb_if.slave  s_ctrl_axis,
    menshen_ctrl_data_arb_if.slave  s_data_axis,
    menshen_ctrl_data_arb_if.master m_axis,
    output logic [31:0]          ctrl_pkt_cnt,
    output logic [31:0]          data_pkt_cnt,
    output logic                 busy
);
    // A zero limit still needs a 1-bit counter so the compare stays legal.
    localparam int RUN_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CTRL = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_nxt;
    logic [31:0]      ctrl_cnt_q;
    logic [31:0]      data_cnt_q;
    logic             ctrl_done;
    logic             data_done;
    logic             force_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            run_cnt    <= '0;
            ctrl_cnt_q <= '0;
            data_cnt_q <= '0;
        end else begin
            state   <= state_nxt;
            run_cnt <= run_nxt;
            if (ctrl_done) begin
                ctrl_cnt_q <= ctrl_cnt_q + 32'd1;
            end
            if (data_done) begin
                data_cnt_q <= data_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_nxt          = state;
        run_nxt            = run_cnt;
        ctrl_done          = 1'b0;
        data_done          = 1'b0;
        m_axis.tdata       = '0;
        m_axis.tkeep       = '0;
        m_axis.tuser       = '0;
        m_axis.tlast       = 1'b0;
        m_axis.tvalid      = 1'b0;
        s_ctrl_axis.tready = 1'b0;
        s_data_axis.tready = 1'b0;
        force_data = (STARVE_LIMIT != 0) && (run_cnt == RUN_MAX) && s_data_axis.tvalid;

        case (state)
            ST_IDLE: begin
                if (s_ctrl_axis.tvalid && !force_data) begin
                    state_nxt = ST_CTRL;
                    // Only count control grants that actually made data wait.
                    if (!s_data_axis.tvalid) begin
                        run_nxt = '0;
                    end else if (run_cnt != RUN_MAX) begin
                        run_nxt = run_cnt + RUN_W'(1);
                    end
                end else if (s_data_axis.tvalid) begin
                    state_nxt = ST_DATA;
                    run_nxt   = '0;
                end
            end
            ST_CTRL: begin
                m_axis.tdata       = s_ctrl_axis.tdata;
                m_axis.tkeep       = s_ctrl_axis.tkeep;
                m_axis.tuser       = s_ctrl_axis.tuser;
                m_axis.tlast       = s_ctrl_axis.tlast;
                m_axis.tvalid      = s_ctrl_axis.tvalid;
                s_ctrl_axis.tready = m_axis.tready;
                ctrl_done = s_ctrl_axis.tvalid && m_axis.tready && s_ctrl_axis.tlast;
                if (ctrl_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                m_axis.tdata       = s_data_axis.tdata;
                m_axis.tkeep       = s_data_axis.tkeep;
                m_axis.tuser       = s_data_axis.tuser;
                m_axis.tlast       = s_data_axis.tlast;
                m_axis.tvalid      = s_data_axis.tvalid;
                s_data_axis.tready = m_axis.tready;
                data_done = s_data_axis.tvalid && m_axis.tready && s_data_axis.tlast;
                if (data_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ctrl_pkt_cnt = ctrl_cnt_q;
    assign data_pkt_cnt = data_cnt_q;
    assign busy         = (state != ST_IDLE);
endmodule

// File: tb/tb_menshen_ctrl_data_arb.sv
// tb/tb_menshen_ctrl_data_arb.sv - randomized model-checked bench for menshen_ctrl_data_arb
module tb_menshen_ctrl_data_arb;
    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int UW = 128;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ctrl_pkt_cnt, data_pkt_cnt, s_ctrl_pkt_cnt, s_data_pkt_cnt;
    logic        busy, s_busy;

    menshen_ctrl_data_arb_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) sc ();
    menshen_ctrl_data_arb_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) sd ();
    menshen_ctrl_data_arb_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) mo ();
    menshen_ctrl_data_arb_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) sc2 ();
    menshen_ctrl_data_arb_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) sd2 ();
    menshen_ctrl_data_arb_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) mo2 ();

    menshen_ctrl_data_arb #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .s_ctrl_axis(sc), .s_data_axis(sd), .m_axis(mo),
        .ctrl_pkt_cnt(ctrl_pkt_cnt), .data_pkt_cnt(data_pkt_cnt), .busy(busy)
    );

    menshen_ctrl_data_arb #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .STARVE_LIMIT(0)) dut_strict (
        .clk(clk), .rst(rst), .s_ctrl_axis(sc2), .s_data_axis(sd2), .m_axis(mo2),
        .ctrl_pkt_cnt(s_ctrl_pkt_cnt), .data_pkt_cnt(s_data_pkt_cnt), .busy(s_busy)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    beat_t cq[$];
    beat_t dq[$];
    bit    mr_pat[$];
    bit    gap_en = 1'b0;
    bit    mr_rand = 1'b0;
    int    d_pops = 0;
    string grant_log = "";

    // Reference: who owns the output (0 none, 1 ctrl, 2 data), how many
    // control packets in a row were granted over a waiting data stream, counts.
    int          m_owner = 0;
    int          m_run = 0;
    logic [31:0] m_ccnt = '0;
    logic [31:0] m_dcnt = '0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic beat_t rand_beat(input bit last);
        beat_t b;
        for (int i = 0; i < DW / 32; i++) b.d[i*32 +: 32] = $urandom;
        b.k = {$urandom, $urandom};
        b.u = {$urandom, $urandom, $urandom, $urandom};
        b.l = last;
        return b;
    endfunction

    task automatic push_pkt(input bit is_ctrl, input int n, input bit fix_keep, input logic [KW-1:0] kv);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b = rand_beat(i == n - 1);
            if (fix_keep && i == n - 1) b.k = kv;
            if (is_ctrl) cq.push_back(b);
            else dq.push_back(b);
        end
    endtask

    // Every cycle: outputs must equal the granted source (or zeros in idle).
    always @(negedge clk) begin
        logic [DW-1:0] e_d;
        logic [KW-1:0] e_k;
        logic [UW-1:0] e_u;
        logic          e_l, e_v, e_cr, e_dr;
        bool_blk: begin end
        e_d = '0; e_k = '0; e_u = '0; e_l = 0; e_v = 0; e_cr = 0; e_dr = 0;
        if (m_owner == 1) begin
            e_d = sc.tdata; e_k = sc.tkeep; e_u = sc.tuser; e_l = sc.tlast;
            e_v = sc.tvalid; e_cr = mo.tready;
        end else if (m_owner == 2) begin
            e_d = sd.tdata; e_k = sd.tkeep; e_u = sd.tuser; e_l = sd.tlast;
            e_v = sd.tvalid; e_dr = mo.tready;
        end
        chk("m_tvalid", DW'(mo.tvalid), DW'(e_v));
        chk("m_tlast", DW'(mo.tlast), DW'(e_l));
        chk("m_tdata", mo.tdata, e_d);
        chk("m_tkeep", DW'(mo.tkeep), DW'(e_k));
        chk("m_tuser", DW'(mo.tuser), DW'(e_u));
        chk("ctrl_tready", DW'(sc.tready), DW'(e_cr));
        chk("data_tready", DW'(sd.tready), DW'(e_dr));
        chk("busy", DW'(busy), DW'(m_owner != 0));
        chk("ctrl_pkt_cnt", DW'(ctrl_pkt_cnt), DW'(m_ccnt));
        chk("data_pkt_cnt", DW'(data_pkt_cnt), DW'(m_dcnt));
        if (sc.tvalid && sc.tready && sc.tlast) grant_log = {grant_log, "C"};
        if (sd.tvalid && sd.tready && sd.tlast) grant_log = {grant_log, "D"};

        if (rst) begin
            m_owner = 0; m_run = 0; m_ccnt = '0; m_dcnt = '0;
        end else if (m_owner == 0) begin
            if (sc.tvalid && !(m_run == 4 && sd.tvalid)) begin
                m_owner = 1;
                m_run = sd.tvalid ? ((m_run < 4) ? m_run + 1 : 4) : 0;
            end else if (sd.tvalid) begin
                m_owner = 2;
                m_run = 0;
            end
        end else if (m_owner == 1) begin
            if (sc.tvalid && mo.tready && sc.tlast) begin m_ccnt++; m_owner = 0; end
        end else begin
            if (sd.tvalid && mo.tready && sd.tlast) begin m_dcnt++; m_owner = 0; end
        end
    end

    // Sources hold tvalid until handshake; optional random gaps and backpressure.
    initial begin
        bit fire_c, fire_d, hold_c, hold_d;
        hold_c = 0; hold_d = 0;
        sc.tvalid = 0; sc.tdata = '0; sc.tkeep = '0; sc.tuser = '0; sc.tlast = 0;
        sd.tvalid = 0; sd.tdata = '0; sd.tkeep = '0; sd.tuser = '0; sd.tlast = 0;
        mo.tready = 1;
        forever begin
            @(negedge clk);
            fire_c = sc.tvalid && sc.tready;
            fire_d = sd.tvalid && sd.tready;
            @(posedge clk);
            #1;
            if (rst) begin
                cq.delete(); dq.delete(); hold_c = 0; hold_d = 0;
            end else begin
                if (fire_c) begin cq.delete(0); hold_c = 0; end
                if (fire_d) begin dq.delete(0); hold_d = 0; d_pops++; end
            end
            if (cq.size() > 0 && (hold_c || !gap_en || $urandom_range(0, 3) != 0)) begin
                hold_c = 1; sc.tvalid = 1;
                sc.tdata = cq[0].d; sc.tkeep = cq[0].k; sc.tuser = cq[0].u; sc.tlast = cq[0].l;
            end else begin
                sc.tvalid = 0; sc.tdata = {16{$urandom}}; sc.tlast = 1'($urandom);
            end
            if (dq.size() > 0 && (hold_d || !gap_en || $urandom_range(0, 3) != 0)) begin
                hold_d = 1; sd.tvalid = 1;
                sd.tdata = dq[0].d; sd.tkeep = dq[0].k; sd.tuser = dq[0].u; sd.tlast = dq[0].l;
            end else begin
                sd.tvalid = 0; sd.tdata = {16{$urandom}}; sd.tlast = 1'($urandom);
            end
            if (mr_pat.size() > 0) mo.tready = mr_pat.pop_front();
            else mo.tready = mr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string nm, input int max_cyc);
        int n;
        n = 0;
        while (!(cq.size() == 0 && dq.size() == 0 && m_owner == 0) && n < max_cyc) begin
            tick();
            n++;
        end
        if (n >= max_cyc) begin
            total++; bad++;
            $display("FAIL %s drain timeout act=%0d cycles exp<%0d", nm, n, max_cyc);
        end
    endtask

    initial begin
        int c_left, d_left, n, base;
        string log2;
        sc2.tvalid = 0; sc2.tdata = '0; sc2.tkeep = '0; sc2.tuser = '0; sc2.tlast = 1;
        sd2.tvalid = 0; sd2.tdata = '0; sd2.tkeep = '0; sd2.tuser = '0; sd2.tlast = 1;
        mo2.tready = 1;

        // Reset held with no traffic; the compare process checks outputs stay zero.
        repeat (3) tick();
        rst = 0;
        tick();
        chk("reset_busy", DW'(busy), '0);
        chk("reset_strict_cnt", DW'(s_ctrl_pkt_cnt), '0);

        // Simultaneous 2-beat requests: control first, then data.
        grant_log = "";
        push_pkt(1, 2, 1, 64'h3);
        push_pkt(0, 2, 0, '0);
        wait_drain("simul", 50);
        chk("simul_order", DW'(grant_log == "CD"), DW'(1));
        chk("simul_ctrl_cnt", DW'(ctrl_pkt_cnt), DW'(1));
        chk("simul_data_cnt", DW'(data_pkt_cnt), DW'(1));

        // Starvation guard with limit 4.
        grant_log = "";
        for (int i = 0; i < 6; i++) push_pkt(1, 1, 0, '0);
        push_pkt(0, 1, 0, '0);
        wait_drain("starve", 100);
        chk("starve_order", DW'(grant_log == "CCCCDCC"), DW'(1));
        if (grant_log != "CCCCDCC") $display("starve order seen %s", grant_log);
        chk("starve_ctrl_cnt", DW'(ctrl_pkt_cnt), DW'(7));
        chk("starve_data_cnt", DW'(data_pkt_cnt), DW'(2));

        // Strict priority instance: same stimulus, data waits for all control.
        log2 = ""; c_left = 6; d_left = 1; n = 0;
        while ((c_left > 0 || d_left > 0) && n < 100) begin
            sc2.tvalid = (c_left > 0); sc2.tdata = {16{$urandom}};
            sd2.tvalid = (d_left > 0); sd2.tdata = {16{$urandom}};
            @(negedge clk);
            if (sc2.tvalid && sc2.tready) begin log2 = {log2, "C"}; c_left--; end
            if (sd2.tvalid && sd2.tready) begin log2 = {log2, "D"}; d_left--; end
            tick();
            n++;
        end
        sc2.tvalid = 0; sd2.tvalid = 0;
        chk("strict_order", DW'(log2 == "CCCCCCD"), DW'(1));
        tick();
        chk("strict_ctrl_cnt", DW'(s_ctrl_pkt_cnt), DW'(6));
        chk("strict_data_cnt", DW'(s_data_pkt_cnt), DW'(1));

        // Backpressure on a 3-beat data packet, control arriving mid-packet.
        grant_log = "";
        base = d_pops;
        mr_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        push_pkt(0, 3, 0, '0);
        n = 0;
        while (d_pops == base && n < 50) begin tick(); n++; end
        chk("bp_first_beat_seen", DW'(d_pops != base), DW'(1));
        push_pkt(1, 1, 0, '0);
        wait_drain("bp", 50);
        chk("bp_order", DW'(grant_log == "DC"), DW'(1));
        chk("bp_data_cnt", DW'(data_pkt_cnt), DW'(3));

        // Randomized traffic with gaps and random backpressure.
        gap_en = 1; mr_rand = 1;
        for (int i = 0; i < 20; i++) begin
            push_pkt(1, $urandom_range(1, 4), 0, '0);
            push_pkt(0, $urandom_range(1, 4), 0, '0);
        end
        wait_drain("random", 3000);
        chk("rand_ctrl_cnt", DW'(ctrl_pkt_cnt), DW'(28));
        chk("rand_data_cnt", DW'(data_pkt_cnt), DW'(23));
        gap_en = 0; mr_rand = 0;

        // Reset on beat 2 of a 3-beat packet.
        base = d_pops;
        push_pkt(0, 3, 0, '0);
        n = 0;
        while (d_pops < base + 1 && n < 50) begin tick(); n++; end
        rst = 1;
        tick();
        @(negedge clk);
        #1;
        chk("rst_mid_tvalid", DW'(mo.tvalid), '0);
        chk("rst_mid_ctrl_cnt", DW'(ctrl_pkt_cnt), '0);
        chk("rst_mid_data_cnt", DW'(data_pkt_cnt), '0);
        tick();
        rst = 0;
        tick();

        // Data counter wrap from all-ones.
        force dut.data_cnt_q = 32'hFFFF_FFFF;
        m_dcnt = 32'hFFFF_FFFF;
        tick();
        release dut.data_cnt_q;
        tick();
        push_pkt(0, 1, 0, '0);
        wait_drain("wrap", 50);
        chk("wrap_data_cnt", DW'(data_pkt_cnt), '0);
        chk("wrap_ctrl_cnt", DW'(ctrl_pkt_cnt), '0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/menshen_ctrl_data_arb.md
# menshen_ctrl_data_arb

Packet-atomic 2:1 AXI-Stream arbiter that shares the single Menshen pipeline input between the control (configuration) packet stream and the data packet stream in the OpenNIC user box. Control packets have priority at packet boundaries, and a starvation guard bounds how long data can wait. A granted packet is forwarded beat-for-beat with zero added latency. Per-stream packet counters are exported for the AXI-Lite status block.

## Interface
Parameters:
- C_S_AXIS_DATA_WIDTH, 512, tdata width; tkeep width = C_S_AXIS_DATA_WIDTH/8
- C_S_AXIS_TUSER_WIDTH, 128, tuser width, passed through unmodified
- STARVE_LIMIT, 4, maximum consecutive control packets granted while data waits; 0 = strict control priority

Ports:
- clk  in  1  stream clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_ctrl_axis_tdata/tkeep/tuser/tlast  in  512/64/128/1  control stream payload
- s_ctrl_axis_tvalid  in  1 ; s_ctrl_axis_tready  out  1
- s_data_axis_tdata/tkeep/tuser/tlast  in  512/64/128/1  data stream payload
- s_data_axis_tvalid  in  1 ; s_data_axis_tready  out  1
- m_axis_tdata/tkeep/tuser/tlast  out  512/64/128/1  to pipeline parser
- m_axis_tvalid  out  1 ; m_axis_tready  in  1
- ctrl_pkt_cnt  out  32  control packets forwarded (tlast handshakes)
- data_pkt_cnt  out  32  data packets forwarded
- busy  out  1  high while in CTRL or DATA state

## Operation
- FSM states: IDLE, CTRL, DATA. Reset state is IDLE.
- IDLE: both s_*_tready = 0 and m_axis_tvalid = 0. The grant decision is registered at the clock edge:
  - if s_ctrl_axis_tvalid and not force_data -> CTRL
  - else if s_data_axis_tvalid -> DATA
  - else stay in IDLE
- force_data = (STARVE_LIMIT != 0) & (run_cnt == STARVE_LIMIT) & s_data_axis_tvalid.
- run_cnt (width clog2(STARVE_LIMIT+1)):
  - on an IDLE->CTRL transition taken while s_data_axis_tvalid = 1: run_cnt + 1, saturating at STARVE_LIMIT
  - on an IDLE->CTRL transition taken while s_data_axis_tvalid = 0: cleared
  - on an IDLE->DATA transition: cleared
- CTRL: m_axis_* = s_ctrl_axis_*; s_ctrl_axis_tready = m_axis_tready; s_data_axis_tready = 0. On a handshake with tlast = 1: ctrl_pkt_cnt + 1, go to IDLE.
- DATA: same as CTRL with the data stream selected; on the tlast handshake, data_pkt_cnt + 1, go to IDLE.
- Once granted, a packet is never interrupted. tvalid gaps inside a packet keep the grant.
- tkeep and tuser are forwarded unchanged. A single-beat packet (tlast on the first beat) is legal.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0 silently.
- busy = (state != IDLE).

## Timing
- Datapath latency: 0 cycles, combinational mux driven by the registered state. No payload registers.
- Arbitration bubble: exactly one IDLE cycle between the last beat of one packet and the first beat of the next, on either stream.
- tready rules:
  - ready never depends on the non-granted stream's tvalid
  - m_axis_tvalid is never asserted in IDLE
- Counters update on the cycle after the tlast handshake. Both counters never increment in the same cycle.
- Simultaneous tvalid on both streams in IDLE: control wins unless force_data is set.
- Reset mid-packet: state returns to IDLE, both readies drop and m_axis_tvalid drops in the cycle after rst is sampled high. The truncated packet is not completed, and the downstream pipeline must tolerate it. run_cnt, ctrl_pkt_cnt and data_pkt_cnt all go to 0.
- Reset values: all s_*_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata/tkeep/tuser = 0 (IDLE drives zeros), busy = 0, counters = 0.

## Test plan
- **Reset and idle:** hold rst 3 cycles, no input valid. All outputs stay 0, busy = 0 and the state remains IDLE.
- **Simultaneous requests:** a 2-beat control packet (second-beat tkeep 0x0000000000000003) and a 2-beat data packet become valid in the same cycle.
  - m_axis carries the control beats first, then one bubble, then the data beats.
  - Final counts: ctrl_pkt_cnt = 1, data_pkt_cnt = 1.
- **Starvation guard:** STARVE_LIMIT = 4, 6 back-to-back control packets with data continuously valid. Grant order is C, C, C, C, D, C, C; run_cnt is cleared after the D.
- **Strict priority:** STARVE_LIMIT = 0, the same stimulus as the starvation guard. All 6 control packets pass before the data packet.
- **Backpressure:** m_axis_tready toggles 1,0,0,1 during a 3-beat data packet, and control becomes valid mid-packet.
  - The data beats stay contiguous and unchanged, s_ctrl_axis_tready stays 0, and control starts only after the data tlast plus one bubble.
- **Reset mid-packet and counter wrap:**
  - Assert rst on beat 2 of a 3-beat packet: m_axis_tvalid is 0 on the next cycle and both counters read 0.
  - Separately, force data_pkt_cnt to 0xFFFFFFFF and send one data packet: the counter reads 0.
